// File: rtl/spi_burst_scheduler.sv
// rtl/spi_burst_scheduler.sv - frames header+payload bursts from a TX FIFO onto an SPI byte engine
module spi_burst_scheduler #(
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int UR_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] fifo_rd_data,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  output logic       eng_start,
  output logic [7:0] eng_tx_data,
  input  logic       eng_busy,
  input  logic       eng_done,
  input  logic [7:0] eng_rx_data,
  output logic       cs_n,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       err_underrun,
  input  logic       err_clr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_XFER  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(CS_HOLD - 1);
  localparam logic [7:0] UR_LAST    = 8'(UR_TIMEOUT - 1);

  logic [2:0] state;
  logic [4:0] remaining;
  logic [3:0] phase_cnt;
  logic [7:0] ur_cnt;
  logic       hdr_pop;
  logic       byte_issue;
  logic       ur_hit;

  // The underrun timer only runs while the engine is free and the FIFO is dry;
  // ur_hit fires on the cycle whose increment would reach UR_TIMEOUT.
  always_comb begin
    hdr_pop    = !rst && (state == S_IDLE) && enable && !fifo_empty;
    byte_issue = !rst && (state == S_LOAD) && !eng_busy && !fifo_empty;
    ur_hit     = (state == S_LOAD) && !eng_busy && fifo_empty && (ur_cnt == UR_LAST);
  end

  assign fifo_rd_en  = hdr_pop | byte_issue;
  assign eng_start   = byte_issue;
  assign eng_tx_data = byte_issue ? fifo_rd_data : 8'h00;
  assign cs_n        = (state == S_IDLE);
  assign busy        = (state != S_IDLE) | hdr_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      remaining    <= 5'd0;
      phase_cnt    <= 4'd0;
      ur_cnt       <= 8'd0;
      rx_valid     <= 1'b0;
      rx_data      <= 8'h00;
      err_underrun <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      // Setting wins over a coincident clear so an abort is never lost.
      if (ur_hit) begin
        err_underrun <= 1'b1;
      end else if (err_clr) begin
        err_underrun <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (hdr_pop) begin
            remaining <= {1'b0, fifo_rd_data[3:0]} + 5'd1;
            phase_cnt <= 4'd0;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (phase_cnt == SETUP_LAST) begin
            phase_cnt <= 4'd0;
            ur_cnt    <= 8'd0;
            state     <= S_LOAD;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        S_LOAD: begin
          if (byte_issue) begin
            state <= S_XFER;
          end else if (ur_hit) begin
            phase_cnt <= 4'd0;
            state     <= S_HOLD;
          end else if (!eng_busy && fifo_empty) begin
            ur_cnt <= ur_cnt + 8'd1;
          end
        end
        S_XFER: begin
          if (eng_done) begin
            rx_data   <= eng_rx_data;
            rx_valid  <= 1'b1;
            remaining <= remaining - 5'd1;
            if (remaining == 5'd1) begin
              phase_cnt <= 4'd0;
              state     <= S_HOLD;
            end else begin
              ur_cnt <= 8'd0;
              state  <= S_LOAD;
            end
          end
        end
        S_HOLD: begin
          if (phase_cnt == HOLD_LAST) begin
            state <= S_IDLE;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_burst_scheduler.sv
// tb/tb_spi_burst_scheduler.sv - directed and randomized checks of spi_burst_scheduler against a frame-level model
module tb_spi_burst_scheduler;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int UR_TO    = 10;
  localparam int XFER_CYC = 8;

  logic       clk = 1'b0;
  logic       rst, enable, err_clr;
  logic [7:0] fifo_rd_data, eng_rx_data, eng_tx_data, rx_data;
  logic       fifo_empty, fifo_rd_en, eng_start, eng_busy, eng_done;
  logic       cs_n, rx_valid, busy, err_underrun;

  spi_burst_scheduler #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .UR_TIMEOUT(UR_TO)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .eng_start(eng_start), .eng_tx_data(eng_tx_data), .eng_busy(eng_busy),
    .eng_done(eng_done), .eng_rx_data(eng_rx_data), .cs_n(cs_n),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
    .err_underrun(err_underrun), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // FIFO model: first-word-fall-through ring
  logic [7:0] fmem [0:255];
  int head = 0, tail = 0;
  assign fifo_empty   = (head == tail);
  assign fifo_rd_data = fmem[head % 256];

  // Byte engine model: busy for XFER_CYC cycles, done in the last one, echoes tx ^ 0x99
  logic       eng_act = 1'b0, eng_done_m = 1'b0, force_busy = 1'b0, force_done = 1'b0;
  int         eng_cnt = 0;
  logic [7:0] eng_byte = 8'h00;
  assign eng_busy    = eng_act | force_busy;
  assign eng_done    = eng_done_m | force_done;
  assign eng_rx_data = eng_byte ^ 8'h99;

  int cyc = 0, pops = 0, starts = 0, rxv = 0, cs_low = 0, windows = 0, viol = 0, err_rises = 0;
  int last_done_cyc = 0, cs_fall_cyc = 0, cs_rise_cyc = 0, last_start_cyc = 0, err_set_cyc = 0;
  logic       prev_cs = 1'b1, err_prev = 1'b0, saw_pop, saw_start, saw_rst;
  logic [7:0] st_data;
  logic [7:0] tx_log[$], rx_log[$], exp_tx[$];

  always @(negedge clk) begin
    cyc++;
    saw_pop = fifo_rd_en; saw_start = eng_start; st_data = eng_tx_data; saw_rst = rst;
    if (fifo_rd_en) pops++;
    if (eng_start) begin
      starts++; tx_log.push_back(eng_tx_data); last_start_cyc = cyc;
      if (eng_busy || !fifo_rd_en) viol++;
    end
    if (rx_valid) begin rxv++; rx_log.push_back(rx_data); end
    if (!cs_n) cs_low++;
    if (prev_cs && !cs_n) begin windows++; cs_fall_cyc = cyc; end
    if (!prev_cs && cs_n) cs_rise_cyc = cyc;
    prev_cs = cs_n;
    if (eng_done) last_done_cyc = cyc;
    if (err_underrun && !err_prev) begin err_rises++; err_set_cyc = cyc; end
    err_prev = err_underrun;
    @(posedge clk); #1;
    if (saw_rst) head = tail;
    else if (saw_pop) head++;
    if (saw_start) begin eng_act = 1'b1; eng_cnt = 1; eng_byte = st_data; end
    else if (eng_act) begin
      if (eng_cnt == XFER_CYC) eng_act = 1'b0; else eng_cnt++;
    end
    eng_done_m = eng_act && (eng_cnt == XFER_CYC);
  end

  int tests = 0, fails = 0;

  task automatic chk(string tag, int obs, int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push(logic [7:0] b);
    fmem[tail % 256] = b; tail++;
  endtask

  task automatic push_frame(logic [7:0] hdr, logic [7:0] seed);
    int n;
    n = int'(hdr[3:0]) + 1;
    push(hdr);
    for (int i = 0; i < n; i++) begin
      push(seed + 8'(i)); exp_tx.push_back(seed + 8'(i));
    end
  endtask

  task automatic clear_logs();
    pops = 0; starts = 0; rxv = 0; cs_low = 0; windows = 0; err_rises = 0; viol = 0;
    tx_log.delete(); rx_log.delete(); exp_tx.delete();
  endtask

  task automatic wait_quiet(string tag);
    int q, n;
    q = 0; n = 0;
    while (q < 4 && n < 3000) begin
      step(1); n++;
      if (cs_n && !busy && (head == tail) && !eng_busy) q++; else q = 0;
    end
    chk({tag, "_quiet"}, int'(q >= 4), 1);
  endtask

  task automatic check_seq(string tag);
    chk({tag, "_starts"}, starts, exp_tx.size());
    chk({tag, "_rxv"}, rxv, exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++) begin
      chk({tag, "_tx"}, int'(tx_log[i]), int'(exp_tx[i]));
      chk({tag, "_rx"}, int'(rx_log[i]), int'(exp_tx[i] ^ 8'h99));
    end
    chk({tag, "_viol"}, viol, 0);
  endtask

  int n, rel_cyc, en_cyc, rxv0, nfr, exp_pops, exp_low, plen;
  logic [7:0] hdr, seed;

  initial begin
    rst = 1'b1; enable = 1'b0; err_clr = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst_cs_n", int'(cs_n), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_en", int'(fifo_rd_en), 0);
    chk("rst_start", int'(eng_start), 0);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_err", int'(err_underrun), 0);

    // Single byte frame
    clear_logs();
    push_frame(8'h00, 8'hA5);
    enable = 1'b1;
    #1;
    chk("pop_cycle_rd_en", int'(fifo_rd_en), 1);
    chk("pop_cycle_busy", int'(busy), 1);
    chk("pop_cycle_cs_n", int'(cs_n), 1);
    wait_quiet("single");
    chk("single_pops", pops, 2);
    chk("single_cs_low", cs_low, CS_SETUP + 1 + XFER_CYC + CS_HOLD);
    chk("single_windows", windows, 1);
    check_seq("single");
    chk("single_rx_data", int'(rx_data), 8'h3C);

    // Maximum burst: 16 payload bytes 0x00..0x0F
    clear_logs();
    push_frame(8'h0F, 8'h00);
    wait_quiet("max");
    chk("max_pops", pops, 17);
    chk("max_windows", windows, 1);
    chk("max_cs_low", cs_low, CS_SETUP + 16 * (1 + XFER_CYC) + CS_HOLD);
    check_seq("max");

    // Underrun: header asks for 4, only 2 supplied
    clear_logs();
    push(8'h03); push(8'h61); push(8'h62);
    exp_tx.push_back(8'h61); exp_tx.push_back(8'h62);
    wait_quiet("ur");
    chk("ur_pops", pops, 3);
    check_seq("ur");
    chk("ur_err", int'(err_underrun), 1);
    chk("ur_err_delay", err_set_cyc - last_done_cyc, 1 + UR_TO);
    chk("ur_hold", cs_rise_cyc - err_set_cyc, CS_HOLD);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("ur_err_cleared", int'(err_underrun), 0);

    // Underrun with err_clr held high: set must still win for a cycle
    clear_logs();
    err_clr = 1'b1;
    push(8'h00);
    wait_quiet("ur_clr");
    err_clr = 1'b0;
    chk("ur_clr_rises", err_rises, 1);
    chk("ur_clr_delay", err_set_cyc - cs_fall_cyc, CS_SETUP + UR_TO);
    chk("ur_clr_err", int'(err_underrun), 0);
    chk("ur_clr_starts", starts, 0);

    // Engine held busy in LOAD
    clear_logs();
    force_busy = 1'b1;
    push_frame(8'h00, 8'h5A);
    n = 0;
    while (cs_n && n < 50) begin step(1); n++; end
    chk("eb_cs_fell", int'(cs_n), 0);
    step(CS_SETUP + 20);
    chk("eb_no_start", starts, 0);
    chk("eb_no_pop", pops, 1);
    chk("eb_no_err", int'(err_underrun), 0);
    force_busy = 1'b0;
    rel_cyc = cyc + 1;
    wait_quiet("eb");
    chk("eb_start_cycle", last_start_cyc, rel_cyc);
    check_seq("eb");

    // Spurious eng_done while idle
    rxv0 = rxv;
    force_done = 1'b1; step(1); force_done = 1'b0; step(2);
    chk("spur_rxv", rxv, rxv0);

    // Reset in the middle of a 4-byte burst
    clear_logs();
    push_frame(8'h03, 8'h40);
    n = 0;
    while (starts == 0 && n < 50) begin step(1); n++; end
    step(3);
    rxv0 = rxv;
    enable = 1'b0; rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_rst_cs_n", int'(cs_n), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_rx_valid", int'(rx_valid), 0);
    step(15);
    chk("mid_rst_no_rx", rxv, rxv0);
    chk("mid_rst_starts", starts, 1);
    clear_logs();
    enable = 1'b1;
    push_frame(8'h01, 8'h11);
    wait_quiet("fresh");
    chk("fresh_cs_low", cs_low, CS_SETUP + 2 * (1 + XFER_CYC) + CS_HOLD);
    check_seq("fresh");

    // Back-to-back frames with enable dropped during the first
    clear_logs();
    push_frame(8'h02, 8'h70);
    push_frame(8'h00, 8'h80);
    n = 0;
    while (starts == 0 && n < 50) begin step(1); n++; end
    enable = 1'b0;
    n = 0;
    while (!(windows == 1 && cs_n) && n < 200) begin step(1); n++; end
    step(10);
    chk("b2b_first_windows", windows, 1);
    chk("b2b_first_pops", pops, 4);
    chk("b2b_first_starts", starts, 3);
    enable = 1'b1;
    en_cyc = cyc + 1;
    wait_quiet("b2b");
    chk("b2b_windows", windows, 2);
    chk("b2b_second_fall", cs_fall_cyc - en_cyc, 1);
    chk("b2b_pops", pops, 6);
    check_seq("b2b");

    // Randomized frame trains against the frame-level model
    for (int it = 0; it < 6; it++) begin
      clear_logs();
      nfr = $urandom_range(1, 3);
      exp_pops = 0; exp_low = 0;
      for (int f = 0; f < nfr; f++) begin
        hdr = 8'($urandom); seed = 8'($urandom);
        plen = int'(hdr[3:0]) + 1;
        push_frame(hdr, seed);
        exp_pops += 1 + plen;
        exp_low += CS_SETUP + plen * (1 + XFER_CYC) + CS_HOLD;
      end
      wait_quiet("rnd");
      chk("rnd_pops", pops, exp_pops);
      chk("rnd_windows", windows, nfr);
      chk("rnd_cs_low", cs_low, exp_low);
      chk("rnd_err", int'(err_underrun), 0);
      check_seq("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_burst_scheduler.md
SPI_BURST_SCHEDULER -- requirements
Module: spi_burst_scheduler

Interface
REQ-001 Parameters SHALL be: CS_SETUP, default 2, cycles cs_n is low before the first byte (1..15); CS_HOLD, default 2, cycles cs_n stays low after the last byte (1..15); UR_TIMEOUT, default 255, cycles to wait for an empty FIFO mid-burst before abort (1..255).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  allows a new burst to start.
- fifo_rd_data  in  8  first-word-fall-through head byte of the TX FIFO.
- fifo_empty  in  1  TX FIFO empty.
- fifo_rd_en  out  1  pop pulse to the TX FIFO.
- eng_start  out  1  one-cycle start pulse to the SPI byte engine.
- eng_tx_data  out  8  byte to shift; valid when eng_start=1.
- eng_busy  in  1  SPI byte engine is shifting.
- eng_done  in  1  one-cycle pulse when a byte completes.
- eng_rx_data  in  8  received byte; valid with eng_done.
- cs_n  out  1  SPI chip select, active low.
- rx_valid  out  1  one-cycle pulse qualifying rx_data.
- rx_data  out  8  captured received byte.
- busy  out  1  high in any state other than IDLE.
- err_underrun  out  1  sticky abort flag.
- err_clr  in  1  clears err_underrun.

Function
REQ-003 Frame format SHALL be a header byte followed by payload bytes; payload length = header[3:0]+1 (1..16 bytes); header[7:4] ignored.
REQ-004 The state machine SHALL have states IDLE, SETUP, LOAD, XFER, HOLD.
REQ-005 IDLE SHALL do the following:
- When enable=1 and fifo_empty=0, pulse fifo_rd_en for 1 cycle.
- Latch header[3:0]+1 into a 5-bit remaining counter.
- Drive cs_n=0 on the next cycle and enter SETUP.
REQ-006 SETUP SHALL hold cs_n=0 for exactly CS_SETUP cycles, then enter LOAD.
REQ-007 LOAD issue condition: when fifo_empty=0 and eng_busy=0, the block SHALL in the same cycle do the following:
- Assert eng_start=1 and fifo_rd_en=1.
- Drive eng_tx_data=fifo_rd_data.
- Enter XFER.
REQ-008 LOAD SHALL wait without pulsing while eng_busy=1; the underrun timer SHALL not advance during this wait.
REQ-009 LOAD underrun handling SHALL be as follows:
- While fifo_empty=1, an 8-bit wait counter increments every cycle; it is cleared on entry to LOAD.
- When the counter reaches UR_TIMEOUT, set err_underrun, pop nothing further and enter HOLD.
REQ-010 XFER SHALL wait for eng_done and, in that cycle, do the following:
- Register rx_data<=eng_rx_data and pulse rx_valid on the next cycle.
- Decrement remaining.
- If the decremented value is 0, enter HOLD; otherwise enter LOAD.
REQ-011 HOLD SHALL keep cs_n=0 for CS_HOLD cycles, then drive cs_n=1 and enter IDLE; IDLE SHALL spend at least 1 cycle with cs_n=1 before the next header pop.
REQ-012 Deasserting enable mid-burst SHALL NOT abort; it only blocks the IDLE->SETUP transition.
REQ-013 Signal usage limits SHALL be as follows:
- At most one fifo_rd_en pulse per cycle.
- fifo_rd_en only in IDLE (header) or LOAD (payload).
- eng_start never while eng_busy=1.
- eng_start never while in XFER.
REQ-014 A spurious eng_done outside XFER SHALL be ignored: no rx_valid, no counter change.
REQ-015 err_underrun SHALL be set only by REQ-009 and cleared by err_clr=1; simultaneous set and clear SHALL leave it set.
REQ-016 busy SHALL be 1 in SETUP, LOAD, XFER and HOLD, and also in the IDLE cycle that pops the header.

Reset
REQ-017 On rst=1 at a clock edge the block SHALL do the following:
- Enter IDLE, with cs_n=1.
- Drive fifo_rd_en=0, eng_start=0, rx_valid=0, rx_data=0, busy=0 and err_underrun=0.
- Clear all counters.
REQ-018 Reset asserted mid-burst SHALL take effect the next edge: cs_n=1, no further pops or starts, and the partial frame is discarded (not resumed).

Verification
REQ-019 Single byte: push 0x00,0xA5; engine echoes 0x3C after 8 cycles; the bench SHALL check all of the following:
- 2 pops total.
- cs_n low for exactly 2+1+8+2 cycles framing one eng_start with eng_tx_data=0xA5.
- One rx_valid with rx_data=0x3C.
REQ-020 Max burst: header 0x0F plus 16 bytes 0x00..0x0F -> 16 eng_start pulses in order 0x00..0x0F, 16 rx_valid pulses, 17 pops, and a single cs_n low window.
REQ-021 Underrun: header 0x03 plus only 2 payload bytes, UR_TIMEOUT=10 -> 2 transfers, then err_underrun=1 exactly 10 cycles after entering LOAD, HOLD for 2 cycles, cs_n=1, and no third eng_start; err_clr then clears the flag.
REQ-022 Engine busy: hold eng_busy=1 for 20 cycles in LOAD with the FIFO non-empty -> no eng_start, no pop and no underrun; eng_start on the first cycle after eng_busy falls.
REQ-023 Reset mid-XFER of a 4-byte burst -> next cycle cs_n=1, busy=0 and no rx_valid; a later fresh frame executes normally.
REQ-024 Back-to-back frames with enable toggled low mid-first-frame -> first frame completes; second starts only after enable=1 and at least one cs_n-high cycle.
